tdc_calib_seq: RTL

Parametrised calibration sequencer for the time-tagger front end. It generates bursts of calibration pulses with programmable period and count on a selectable subset of TDC channels, and muxes them into each channel's signal path. It also provides a free-running test clock. It sits between the differential input buffers and the timetagger core, and replaces the fixed divided-oscillator calibration source with a deterministic, counted, software-controlled sequence.

---
 rtl/tdc_calib_seq.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/tdc_calib_seq.sv
// ----------------------------------------------------------------------------
// tdc_calib_seq
//
// Calibration sequencer for the time-tagger front end. On request it emits a
// counted burst of square calibration pulses (programmable half-period and
// pulse count) on a selectable subset of TDC channels, and muxes that
// waveform into each selected channel's path while the burst is running.
// A free-running counter provides an independent test clock.
//
// Ports
//   clk_i        system clock, all logic on the rising edge
//   reset_i      asynchronous active-high reset
//   start_i      burst request, only honoured while idle
//   abort_i      terminate a running burst on the next edge (highest priority)
//   div_i        half-period of a calibration pulse, in clk_i cycles
//   burst_len_i  number of pulses in the burst
//   chan_mask_i  channels that receive the calibration waveform
//   signal_i     buffered external TDC inputs
//   signal_o     per-channel input to the timetagger core (combinational mux)
//   calib_o      registered calibration waveform, already masked
//   busy_o       burst in progress (RUN or GUARD)
//   done_o       one-cycle pulse on normal completion (not on abort)
//   pulses_o     rising edges emitted in the current / last burst
//   test_clk_o   MSB of the free-running test counter
//   dbg_state_o  current sequencer state, for observation only
//
// Handshake: start_i is a single-cycle level sampled on a rising edge while
// the sequencer is idle; done_o answers it exactly once per accepted request
// unless the burst is aborted. There is no back-pressure.
// ----------------------------------------------------------------------------
module tdc_calib_seq #(
    parameter int g_CHANNELS    = 2,
    parameter int g_DIV_WIDTH   = 19,
    parameter int g_BURST_WIDTH = 16
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     start_i,
    input  logic                     abort_i,
    input  logic [g_DIV_WIDTH-1:0]   div_i,
    input  logic [g_BURST_WIDTH-1:0] burst_len_i,
    input  logic [g_CHANNELS-1:0]    chan_mask_i,
    input  logic [g_CHANNELS-1:0]    signal_i,
    output logic [g_CHANNELS-1:0]    signal_o,
    output logic [g_CHANNELS-1:0]    calib_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic [g_BURST_WIDTH-1:0] pulses_o,
    output logic                     test_clk_o,
    output logic [1:0]               dbg_state_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_GUARD = 2'd2
    } state_t;

    localparam logic [g_DIV_WIDTH-1:0]   c_DIV_ONE   = 1;
    localparam logic [g_BURST_WIDTH-1:0] c_BURST_ONE = 1;

    state_t                     r_state;
    logic [g_DIV_WIDTH-1:0]     r_div;
    logic [g_BURST_WIDTH-1:0]   r_len;
    logic [g_CHANNELS-1:0]      r_mask;
    logic [g_DIV_WIDTH-1:0]     r_phase;
    logic                       r_level;
    logic [g_BURST_WIDTH-1:0]   r_pulses;
    logic [g_CHANNELS-1:0]      r_calib;
    logic                       r_busy;
    logic                       r_done;
    logic [g_DIV_WIDTH-1:0]     r_tclk;
    logic [g_CHANNELS-1:0]      w_sel;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state  <= ST_IDLE;
            r_div    <= '0;
            r_len    <= '0;
            r_mask   <= '0;
            r_phase  <= '0;
            r_level  <= 1'b0;
            r_pulses <= '0;
            r_calib  <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_tclk   <= '0;
        end else begin
            r_tclk <= r_tclk + c_DIV_ONE;
            r_done <= 1'b0;

            if (abort_i && (r_state != ST_IDLE)) begin
                // Pulse count is deliberately kept so software can see how
                // far the burst got.
                r_state <= ST_IDLE;
                r_level <= 1'b0;
                r_calib <= '0;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (start_i && !abort_i) begin
                            r_div    <= div_i;
                            r_len    <= burst_len_i;
                            r_mask   <= chan_mask_i;
                            r_pulses <= '0;
                            if ((div_i == '0) || (burst_len_i == '0)) begin
                                // Nothing to emit: acknowledge immediately.
                                r_done <= 1'b1;
                            end else begin
                                // Entering RUN is itself the first rising edge.
                                r_state  <= ST_RUN;
                                r_phase  <= div_i - c_DIV_ONE;
                                r_level  <= 1'b1;
                                r_calib  <= chan_mask_i;
                                r_busy   <= 1'b1;
                                r_pulses <= c_BURST_ONE;
                            end
                        end
                    end

                    ST_RUN: begin
                        if (r_phase != '0) begin
                            r_phase <= r_phase - c_DIV_ONE;
                        end else begin
                            r_phase <= r_div - c_DIV_ONE;
                            if (r_level) begin
                                r_level <= 1'b0;
                                r_calib <= '0;
                            end else if (r_pulses == r_len) begin
                                // Low half of the last pulse has ended.
                                r_state <= ST_GUARD;
                            end else begin
                                r_level  <= 1'b1;
                                r_calib  <= r_mask;
                                r_pulses <= r_pulses + c_BURST_ONE;
                            end
                        end
                    end

                    ST_GUARD: begin
                        if (r_phase != '0) begin
                            r_phase <= r_phase - c_DIV_ONE;
                        end else begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end

                    default: begin
                        r_state <= ST_IDLE;
                        r_level <= 1'b0;
                        r_calib <= '0;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Only selected channels are overridden, and only while a burst runs.
    assign w_sel    = {g_CHANNELS{r_busy}} & r_mask;
    assign signal_o = (w_sel & r_calib) | (~w_sel & signal_i);

    assign calib_o     = r_calib;
    assign busy_o      = r_busy;
    assign done_o      = r_done;
    assign pulses_o    = r_pulses;
    assign test_clk_o  = r_tclk[g_DIV_WIDTH-1];
    assign dbg_state_o = r_state;

endmodule
